// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: widths, HALT opcode and FSM states.
package fetch_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 16;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HALT_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/i_fetch.sv
// Instruction fetch sequencer: owns the PC, buffers one fetched word for decode,
// handles redirects and stops fetching once a HALT opcode has been captured.
module i_fetch #(
    parameter int unsigned                       PC_W     = fetch_pkg::PC_W,
    parameter int unsigned                       INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [fetch_pkg::OPC_W-1:0]       OPC_HALT = fetch_pkg::OPC_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    import fetch_pkg::*;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_valid;
    logic               r_halted;

    logic               w_free;
    logic               w_is_halt;

    assign w_free    = !r_valid || instr_ready;
    assign w_is_halt = (imem_data[OPC_MSB:OPC_LSB] == OPC_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_pc    <= '0;
                    end
                end
                ST_RUN: begin
                    if (redirect) begin
                        r_valid <= 1'b0;
                        r_pc    <= redirect_pc;
                    end else if (w_free) begin
                        r_instr    <= imem_data;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        // HALT word is delivered but the PC parks on it
                        if (w_is_halt) begin
                            r_state <= ST_HALT_WAIT;
                        end else begin
                            r_pc <= r_pc + PC_W'(1);
                        end
                    end
                end
                ST_HALT_WAIT: begin
                    if (redirect) begin
                        r_valid  <= 1'b0;
                        r_pc     <= redirect_pc;
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end else if (!r_valid) begin
                        if (start) begin
                            r_state  <= ST_RUN;
                            r_pc     <= '0;
                            r_halted <= 1'b0;
                        end else begin
                            r_halted <= 1'b1;
                        end
                    end else if (instr_ready) begin
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;

endmodule
